// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the digit-serial operand shift register.
// State encoding for the load/shift controller and counter width helper.
// No logic of its own.
package shiftreg_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width needed to hold the digit count 0..WIDTH/DIGIT inclusive.
   function automatic int cnt_w(input int width, input int digit);
      return $clog2(width / digit + 1);
   endfunction

endpackage

// File: rtl/shiftreg_digit_cnt.sv
// Loadable down-counter of digits still to emit, with last-digit detect and done pulse.
// Latency: remaining/last are registered state; done is a registered one-cycle pulse.
// Backpressure: frozen when i_en is low, except done which always self-clears.
module shiftreg_digit_cnt
   import shiftreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_en,
   input  logic                            i_clr,
   input  logic                            i_ld,
   input  logic                            i_dec,
   output logic [cnt_w(WIDTH, DIGIT)-1:0]  o_remaining,
   output logic                            o_last,
   output logic                            o_done
);

   localparam int CW   = cnt_w(WIDTH, DIGIT);
   localparam int NDIG = WIDTH / DIGIT;

   logic [CW-1:0] r_rem;
   logic          r_done;
   logic          w_zero;
   logic          w_last;

   assign w_zero = (r_rem == '0);
   assign w_last = (r_rem == CW'(1));

   // Digit count: clear beats load beats decrement; decrement saturates at zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rem <= '0;
      end else if (i_en) begin
         if (i_clr)
            r_rem <= '0;
         else if (i_ld)
            r_rem <= CW'(NDIG);
         else if (i_dec && !w_zero)
            r_rem <= r_rem - CW'(1);
      end
   end

   // Done pulses only when the final digit is actually consumed, never on clr/ld/freeze.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_done <= 1'b0;
      else
         r_done <= i_en & ~i_clr & ~i_ld & i_dec & w_last;
   end

   assign o_remaining = r_rem;
   assign o_last      = w_last;
   assign o_done      = r_done;

endmodule

// File: rtl/shiftreg_digit.sv
// Load-and-shift operand serialiser emitting DIGIT bits per enabled step (LSB-first;
// MSB-first selectable at load when SHIFTREG_DIR_EN is defined). Latency: first digit
// one cycle after load. Backpressure: i_en low freezes all state; done still self-clears.
module shiftreg_digit
   import shiftreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_en,
   input  logic                            i_clr,
   input  logic                            i_ld,
   input  logic [WIDTH-1:0]                i_a,
`ifdef SHIFTREG_DIR_EN
   input  logic                            i_msb_first,
`endif
   output logic [DIGIT-1:0]                o_a_digit,
   output logic                            o_busy,
   output logic                            o_last,
   output logic [cnt_w(WIDTH, DIGIT)-1:0]  o_remaining,
   output logic                            o_done
);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_width
         $fatal(1, "shiftreg_digit: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic             w_msb;
   logic             w_last;
   logic             w_shifting;

   assign w_shifting = (r_state == SHIFT);

`ifdef SHIFTREG_DIR_EN
   logic r_msb;

   // Direction is captured with the operand so it stays fixed for the whole operation.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_msb <= 1'b0;
      else if (i_en && !i_clr && i_ld)
         r_msb <= i_msb_first;
   end

   assign w_msb = r_msb;
`else
   assign w_msb = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state: clr, then ld, then leave SHIFT after the final digit.
   always_comb begin
      w_state_nxt = r_state;
      if (i_en) begin
         if (i_clr)
            w_state_nxt = IDLE;
         else if (i_ld)
            w_state_nxt = SHIFT;
         else if (w_shifting && w_last)
            w_state_nxt = IDLE;
      end
   end

   // Operand register; zero fill means it reads all-zero once every digit is out.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data <= '0;
      end else if (i_en) begin
         if (i_clr)
            r_data <= '0;
         else if (i_ld)
            r_data <= i_a;
         else if (w_shifting)
            r_data <= w_msb ? (r_data << DIGIT) : (r_data >> DIGIT);
      end
   end

   shiftreg_digit_cnt #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) u_cnt (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_clr       (i_clr),
      .i_ld        (i_ld),
      .i_dec       (w_shifting),
      .o_remaining (o_remaining),
      .o_last      (w_last),
      .o_done      (o_done)
   );

   assign o_a_digit = w_msb ? r_data[WIDTH-1 -: DIGIT] : r_data[DIGIT-1:0];
   assign o_busy    = w_shifting;
   assign o_last    = w_shifting & w_last;

endmodule

// File: tb/tb_shiftreg_digit.sv
module tb_shiftreg_digit;

   localparam int W  = 8;
   localparam int D  = 2;
   localparam int ND = W / D;
   localparam int CW = $clog2(ND + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic          ld;
   logic [W-1:0]  a;
   logic          msb_first;
   logic [D-1:0]  a_digit;
   logic          busy;
   logic          last;
   logic [CW-1:0] remaining;
   logic          done;

   shiftreg_digit #(
      .WIDTH (W),
      .DIGIT (D)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_clr       (clr),
      .i_ld        (ld),
      .i_a         (a),
`ifdef SHIFTREG_DIR_EN
      .i_msb_first (msb_first),
`endif
      .o_a_digit   (a_digit),
      .o_busy      (busy),
      .o_last      (last),
      .o_remaining (remaining),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dig;
      int rem;
      int busy;
      int last;
      int done;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: the operand as a list of digits still to be emitted.
   int   mq[$];
   bit   m_done;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_load(input logic [W-1:0] val, input bit msb);
      int sh;
      mq.delete();
      for (int k = 0; k < ND; k++) begin
         sh = msb ? (W - (k + 1) * D) : (k * D);
         mq.push_back(int'(val >> sh) & ((1 << D) - 1));
      end
   endfunction

   function automatic exp_t model_view();
      exp_t x;
      x.dig  = (mq.size() > 0) ? mq[0] : 0;
      x.rem  = mq.size();
      x.busy = (mq.size() > 0) ? 1 : 0;
      x.last = (mq.size() == 1) ? 1 : 0;
      x.done = m_done ? 1 : 0;
      return x;
   endfunction

   // Drive one cycle of inputs, advance the model, queue what must appear after the edge.
   task automatic step(input bit e, input bit c, input bit l, input logic [W-1:0] v, input bit m);
      bit dn;
      bit mm;
      dn = 1'b0;
      mm = 1'b0;
      @(negedge clk);
      en  = e;
      clr = c;
      ld  = l;
      a   = v;
`ifdef SHIFTREG_DIR_EN
      msb_first = m;
      mm        = m;
`endif
      if (e) begin
         if (c)
            mq.delete();
         else if (l)
            model_load(v, mm);
         else if (mq.size() > 0) begin
            void'(mq.pop_front());
            dn = (mq.size() == 0);
         end
      end
      m_done = dn;
      sbq.push_back(model_view());
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
         @(posedge clk);
         #3;
      end
      check("scoreboard_drain", sbq.size(), 0);
   endtask

   task automatic check_zero(input string nm);
      check({nm, "_digit"}, int'(a_digit), 0);
      check({nm, "_rem"},   int'(remaining), 0);
      check({nm, "_busy"},  int'(busy), 0);
      check({nm, "_last"},  int'(last), 0);
      check({nm, "_done"},  int'(done), 0);
   endtask

   // Monitor: every post-edge sample is compared against the oldest queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            check("a_digit",   int'(a_digit),   x.dig);
            check("remaining", int'(remaining), x.rem);
            check("busy",      int'(busy),      x.busy);
            check("last",      int'(last),      x.last);
            check("done",      int'(done),      x.done);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; a = '0; msb_first = 1'b0;
      mq.delete();
      m_done = 1'b0;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic LSB-first operand: digits 0,1,3,2 then done.
      step(1, 0, 1, 8'hB4, 0);
      repeat (4) step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);

`ifdef SHIFTREG_DIR_EN
      // MSB-first operand: digits 2,3,1,0.
      step(1, 0, 1, 8'hB4, 1);
      repeat (5) step(1, 0, 0, 8'h00, 0);
`endif

      // Enable gating: remaining holds while en is low.
      step(1, 0, 1, 8'hFF, 0);
      step(1, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      repeat (3) step(1, 0, 0, 8'h00, 0);

      // Restart mid-operation: no done for the aborted operand.
      step(1, 0, 1, 8'hB4, 0);
      repeat (2) step(1, 0, 0, 8'h00, 0);
      step(1, 0, 1, 8'h0F, 0);
      step(1, 0, 0, 8'h00, 0);

      // clr and ld together: clr wins.
      step(1, 1, 1, 8'h55, 0);
      step(1, 0, 0, 8'h00, 0);

      // Load on the same edge as the final shift: load wins, no done.
      step(1, 0, 1, 8'hC3, 0);
      repeat (3) step(1, 0, 0, 8'h00, 0);
      step(1, 0, 1, 8'h5A, 0);
      repeat (5) step(1, 0, 0, 8'h00, 0);

      // Done self-clears while frozen.
      step(1, 0, 1, 8'h96, 0);
      repeat (4) step(1, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      drain();

      // Asynchronous reset mid-shift with two digits remaining.
      step(1, 0, 1, 8'hB4, 0);
      repeat (2) step(1, 0, 0, 8'h00, 0);
      drain();
      check("pre_rst_rem", int'(remaining), 2);
      #1;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      mq.delete();
      m_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) step(1, 0, 0, 8'h00, 0);
      step(1, 0, 1, 8'h3C, 0);
      repeat (5) step(1, 0, 0, 8'h00, 0);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 6) == 0, W'($urandom), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shiftreg_digit.md
# shiftreg_digit

Parametrised load-and-shift operand serialiser for the modular-multiplication datapath. It loads a WIDTH-bit operand and emits it DIGIT bits per enabled step, by default least-significant digit first. It tracks the digits remaining and flags the last digit, so the Montgomery multiplier controller can run radix-2^DIGIT iterations without keeping its own bit counter. It replaces the single-bit operand shift register in the multiplier's A-operand path.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT
- DIGIT, 1, bits emitted per step (radix 2^DIGIT)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  step enable; no state change when low, except for rst
- clr  in  1  synchronous clear; highest priority after rst; acts only when en=1
- ld  in  1  load request; acts only when en=1
- a  in  WIDTH  operand, sampled when en & ld & !clr
- a_digit  out  DIGIT  current digit (combinational from register)
- busy  out  1  operand loaded and digits pending
- last  out  1  busy and remaining==1
- remaining  out  $clog2(WIDTH/DIGIT+1)  digits still to emit
- done  out  1  registered one-cycle pulse after the final digit is consumed
- msb_first  in  1  direction select, sampled at load; present only with SHIFTREG_DIR_EN

## Operation
- NDIG = WIDTH/DIGIT. States: IDLE, SHIFT.
- Priority per edge when en=1: clr, then ld, then shift. clr zeroes the register, sets remaining=0, goes to IDLE, and forces done=0.
- ld, in any state: register=a, remaining=NDIG, go to SHIFT. A load while busy restarts the operation; the old operand is discarded and done is not pulsed.
- Shift (SHIFT, en=1, no ld/clr):
  - LSB-first: register >> DIGIT with zero fill at the top.
  - MSB-first: register << DIGIT with zero fill at the bottom.
  - remaining decrements.
- When remaining==1 and a shift occurs: go to IDLE, remaining=0, done=1 on the next cycle only.
- a_digit: LSB-first = reg[DIGIT-1:0]; MSB-first = reg[WIDTH-1:WIDTH-DIGIT]. After the final shift the register reads all-zero, so a_digit=0 in IDLE.
- In IDLE, en=1 with no ld/clr leaves the register unchanged (already zero); remaining stays 0.
- en=0 freezes all state. done still deasserts after its single cycle.

## Timing
- Reset values: register 0, remaining 0, busy 0, last 0, done 0, a_digit 0, state IDLE.
- Load-to-first-digit latency: 1 cycle. a_digit is valid in the cycle after the ld edge.
- Each enabled cycle in SHIFT consumes exactly one digit. A full operand takes NDIG enabled cycles.
- done asserts on the edge that consumes the last digit and deasserts on the following edge.
- rst mid-operation returns all outputs to reset values immediately; no done pulse.
- clr and ld together: clr wins. ld on the same edge as the final shift: the load wins and done stays low.

## Configuration
- SHIFTREG_DIR_EN defined: msb_first port exists and is latched at load into a direction flop (reset 0); a_digit and the shift direction follow that flop.
- Not defined: no port and no flop; LSB-first only, with area equal to the fixed-direction design.

## Structure
- Package shiftreg_pkg: state enum (IDLE, SHIFT) and the counter-width function cnt_w(WIDTH,DIGIT) = $clog2(WIDTH/DIGIT+1).
- One sub-module: shiftreg_digit_cnt, a loadable down-counter with zero detect that supplies remaining, last, and the done pulse. The datapath register stays in the top level.
- Elaboration check: WIDTH % DIGIT == 0, otherwise a fatal error.

## Test plan
- WIDTH=8, DIGIT=2, a=8'hB4, en=1, load then 4 shifts:
  - a_digit = 0,1,3,2 on successive cycles
  - last high on the 4th digit
  - done high exactly one cycle after it
  - remaining 4→3→2→1→0
- Same setup with SHIFTREG_DIR_EN and msb_first=1 → a_digit = 2,3,1,0.
- Load 8'hFF, then en toggled 1,0,0,1 → digits advance only on en=1 cycles; remaining holds at 3 during the en=0 cycles.
- Reload 8'h0F after 2 shifts of 8'hB4 → remaining=4, a_digit=3, no done pulse for the aborted operand.
- ld and clr together with a=8'h55 → register 0, busy 0, remaining 0; a_digit=0.
- Assert rst mid-shift (remaining=2) → all outputs 0 asynchronously; after release, IDLE until the next ld.
